alu_issue_ctrl: RTL and testbench
=================================

ALU_ISSUE_CTRL -- requirements
Module: alu_issue_ctrl

Interface
- REQ-001: The block SHALL have parameter MUL_LATENCY, default 2, meaning execute cycles for MUL (legal range 1..15).
- REQ-002: The block SHALL have parameter DIV_LATENCY, default 8, meaning execute cycles for DIV/MOD when the multicycle feature is compiled in (legal range 1..15).
- REQ-003: clk  input  1  single clock; all logic is rising-edge.
- REQ-004: rst  input  1  reset, synchronous, active-high.
- REQ-005: in_valid  input  1  the issued operation is valid.
- REQ-006: in_ready  output  1  the block accepts an operation this cycle.
- REQ-007: opcode  input  4  0 ADD, 1 SUB, 2 CMP, 3 OR, 4 AND, 5 NOT, 6 LSL, 7 LSR, 8 ASR, 9 MUL, 10 DIV, 11 MOD, 12 MOV; 13..15 illegal.
- REQ-008: op_a / op_b  input  32 each  source operands.
- REQ-009: rd  input  4  destination register tag.
- REQ-010: alu_ctrl  output  aluctrl_t  one-hot ALU control (isAdd..isMov, in opcode order).
- REQ-011: alu_a / alu_b  output  32 each  ALU operands.
- REQ-012: alu_result  input  32  ALU result.
- REQ-013: alu_flag  input  flag_t  ALU flags GT/ET.
- REQ-014: out_valid  output  1  a result is presented.
- REQ-015: out_ready  input  1  downstream accepts the result.
- REQ-016: out_result  output  32; out_gt, out_et  output  1 each; out_rd  output  4; out_illegal  output  1.

Function
- REQ-017: The FSM SHALL have exactly three states: IDLE, EXEC, DONE.
- REQ-018: in_ready SHALL be 1 in IDLE, and 1 in DONE only when out_ready is 1; otherwise it SHALL be 0.
- REQ-019: On handshake (in_valid & in_ready), the block SHALL latch opcode, op_a, op_b and rd, then enter EXEC with cnt = latency-1.
- REQ-020: The latency SHALL be 1 for opcodes 0..8 and 12, MUL_LATENCY for 9, and DIV_LATENCY or 1 for 10/11 according to REQ-034/035.
- REQ-021: In EXEC, alu_ctrl SHALL have exactly the one bit of the latched opcode set, and alu_a/alu_b SHALL hold the latched operands stable for every EXEC cycle.
- REQ-022: In IDLE and DONE, alu_ctrl SHALL be all-zero; alu_a/alu_b SHALL retain their last values.
- REQ-023: In EXEC with cnt != 0, cnt SHALL decrement.
- REQ-024: In EXEC with cnt == 0, the block SHALL register alu_result into out_result, alu_flag.GT into out_gt, alu_flag.ET into out_et, and the latched rd into out_rd, clear out_illegal, and enter DONE.
- REQ-025: An accepted illegal opcode (13..15) SHALL go directly to DONE with out_result=0, out_gt=0, out_et=0, out_illegal=1, and alu_ctrl SHALL never assert for it.
- REQ-026: In DONE, out_valid SHALL be 1 and all out_* SHALL remain stable until out_ready.
- REQ-027: In DONE with out_ready=1 and no in_valid, the block SHALL go to IDLE.
- REQ-028: In DONE with out_ready=1 and in_valid=1 (simultaneous drain and issue), the block SHALL latch the new operation and go to EXEC with no bubble.
- REQ-029: Timing for a 1-cycle op accepted at edge T: EXEC during cycle T+1, out_valid=1 from T+2; a MUL with default latency SHALL give out_valid=1 from T+3.
- REQ-030: out_valid SHALL be 0 in IDLE and EXEC.

Reset
- REQ-031: While rst=1 at a clock edge, the state SHALL become IDLE, cnt=0, out_valid=0, in_ready=0 for that cycle, alu_ctrl=0, alu_a=alu_b=0, and out_result/out_gt/out_et/out_rd/out_illegal=0.
- REQ-032: Reset asserted mid-EXEC or in DONE SHALL discard the pending operation with no result emitted; the first cycle after reset deasserts SHALL have in_ready=1.

Configuration
- REQ-033: Macro ALU_MULTICYCLE_DIV_EN SHALL select the DIV/MOD latency.
- REQ-034: With ALU_MULTICYCLE_DIV_EN defined, DIV and MOD SHALL take DIV_LATENCY EXEC cycles.
- REQ-035: Without ALU_MULTICYCLE_DIV_EN, DIV and MOD SHALL take 1 EXEC cycle, DIV_LATENCY SHALL be ignored, and all other behaviour SHALL be identical.

Verification
- REQ-036: ADD op_a=5, op_b=7, rd=3 accepted at T -> alu_ctrl.isAdd=1 during T+1 only; out_valid at T+2 with out_result=12, out_rd=3.
- REQ-037: CMP op_a=9, op_b=9 -> out_et=1, out_gt=0; then CMP op_a=10, op_b=9 -> out_gt=1, out_et=0.
- REQ-038: With macro and DIV_LATENCY=8, DIV op_a=100, op_b=7 at T -> in_ready=0 during T+1..T+8; out_result=14 with out_valid at T+9; the same case without macro -> out_valid at T+2.
- REQ-039: Backpressure: out_ready=0 for 3 cycles while in DONE -> out_* held constant and in_ready=0; out_ready=1 together with in_valid=1 -> the next op enters EXEC the following cycle.
- REQ-040: Opcode 14 -> alu_ctrl stays zero; out_valid at T+1 with out_illegal=1, out_result=0.
- REQ-041: rst pulsed during cycle T+3 of a DIV -> out_valid never asserts for that op; the cycle after rst deasserts has in_ready=1 and all outputs zero.

Source files
------------

// File: rtl/alu_issue_ctrl_if.sv
// rtl/alu_issue_ctrl_if.sv - shared types and issue/ALU/result bundle for alu_issue_ctrl
//
// Package alu_issue_pkg:
//   aluctrl_t : one-hot ALU control, bit n corresponds to opcode n (isAdd = bit 0 ... isMov = bit 12)
//   flag_t    : ALU flags GT (greater-than) and ET (equal-to)
//
// Interface alu_issue_ctrl_if (modport slave = alu_issue_ctrl, modport master = issuer/ALU/consumer):
//   issue  : in_valid, in_ready, opcode[3:0], op_a[31:0], op_b[31:0], rd[3:0]
//   ALU    : alu_ctrl, alu_a[31:0], alu_b[31:0], alu_result[31:0], alu_flag
//   result : out_valid, out_ready, out_result[31:0], out_gt, out_et, out_rd[3:0], out_illegal

package alu_issue_pkg;

    // Declared MSB first so that the bit index equals the opcode value.
    typedef struct packed {
        logic isMov;
        logic isMod;
        logic isDiv;
        logic isMul;
        logic isAsr;
        logic isLsr;
        logic isLsl;
        logic isNot;
        logic isAnd;
        logic isOr;
        logic isCmp;
        logic isSub;
        logic isAdd;
    } aluctrl_t;

    typedef struct packed {
        logic GT;
        logic ET;
    } flag_t;

endpackage

interface alu_issue_ctrl_if;
    import alu_issue_pkg::*;

    logic        in_valid;
    logic        in_ready;
    logic [3:0]  opcode;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [3:0]  rd;

    aluctrl_t    alu_ctrl;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [31:0] alu_result;
    flag_t       alu_flag;

    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic        out_gt;
    logic        out_et;
    logic [3:0]  out_rd;
    logic        out_illegal;

    modport slave (
        input  in_valid, opcode, op_a, op_b, rd, alu_result, alu_flag, out_ready,
        output in_ready, alu_ctrl, alu_a, alu_b,
        output out_valid, out_result, out_gt, out_et, out_rd, out_illegal
    );

    modport master (
        output in_valid, opcode, op_a, op_b, rd, alu_result, alu_flag, out_ready,
        input  in_ready, alu_ctrl, alu_a, alu_b,
        input  out_valid, out_result, out_gt, out_et, out_rd, out_illegal
    );

endinterface

// File: rtl/alu_issue_ctrl.sv
// rtl/alu_issue_ctrl.sv - single-issue ALU sequencer with per-opcode execute latency
//
// Ports:
//   clk : rising-edge clock
//   rst : synchronous active-high reset
//   bus : alu_issue_ctrl_if.slave (issue handshake, ALU drive/return, result handshake)
// Parameters:
//   MUL_LATENCY : EXEC cycles for MUL (1..15)
//   DIV_LATENCY : EXEC cycles for DIV/MOD when ALU_MULTICYCLE_DIV_EN is defined (1..15)
// Build option:
//   ALU_MULTICYCLE_DIV_EN : when defined, DIV/MOD take DIV_LATENCY cycles; otherwise 1 cycle

module alu_issue_ctrl
    import alu_issue_pkg::*;
#(
    parameter int MUL_LATENCY = 2,
    parameter int DIV_LATENCY = 8
) (
    input  logic             clk,
    input  logic             rst,
    alu_issue_ctrl_if.slave  bus
);

`ifdef ALU_MULTICYCLE_DIV_EN
    localparam bit DIV_MULTICYCLE = 1'b1;
`else
    localparam bit DIV_MULTICYCLE = 1'b0;
`endif

    localparam logic [3:0] OP_MUL  = 4'd9;
    localparam logic [3:0] OP_DIV  = 4'd10;
    localparam logic [3:0] OP_MOD  = 4'd11;
    localparam logic [3:0] OP_LAST = 4'd12;

    // The counter is loaded with latency-1 so that cnt==0 marks the final EXEC cycle.
    localparam logic [3:0] MUL_CNT = 4'(MUL_LATENCY - 1);
    localparam logic [3:0] DIV_CNT = 4'(DIV_LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        DONE
    } state_t;

    state_t     state;
    logic [3:0] cnt;
    logic [3:0] rd_q;
    logic [3:0] start_cnt;
    logic       accept;
    logic       illegal_in;

    // A finished result may be drained and a new op accepted on the same edge.
    assign bus.in_ready = !rst && ((state == IDLE) || (state == DONE && bus.out_ready));
    assign accept       = bus.in_valid && bus.in_ready;
    assign illegal_in   = bus.opcode > OP_LAST;

    always_comb begin
        start_cnt = 4'd0;
        if (bus.opcode == OP_MUL) begin
            start_cnt = MUL_CNT;
        end else if ((bus.opcode == OP_DIV || bus.opcode == OP_MOD) && DIV_MULTICYCLE) begin
            start_cnt = DIV_CNT;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= IDLE;
            cnt             <= 4'd0;
            rd_q            <= 4'd0;
            bus.alu_ctrl    <= '0;
            bus.alu_a       <= 32'd0;
            bus.alu_b       <= 32'd0;
            bus.out_valid   <= 1'b0;
            bus.out_result  <= 32'd0;
            bus.out_gt      <= 1'b0;
            bus.out_et      <= 1'b0;
            bus.out_rd      <= 4'd0;
            bus.out_illegal <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (state == DONE && bus.out_ready) begin
                        state         <= IDLE;
                        bus.out_valid <= 1'b0;
                    end
                    if (accept) begin
                        rd_q <= bus.rd;
                        if (illegal_in) begin
                            // Illegal ops never touch the ALU; report straight away.
                            state           <= DONE;
                            bus.out_valid   <= 1'b1;
                            bus.out_result  <= 32'd0;
                            bus.out_gt      <= 1'b0;
                            bus.out_et      <= 1'b0;
                            bus.out_rd      <= bus.rd;
                            bus.out_illegal <= 1'b1;
                        end else begin
                            state        <= EXEC;
                            cnt          <= start_cnt;
                            bus.alu_ctrl <= aluctrl_t'(13'd1 << bus.opcode);
                            bus.alu_a    <= bus.op_a;
                            bus.alu_b    <= bus.op_b;
                        end
                    end
                end
                EXEC: begin
                    if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end else begin
                        state           <= DONE;
                        bus.alu_ctrl    <= '0;
                        bus.out_valid   <= 1'b1;
                        bus.out_result  <= bus.alu_result;
                        bus.out_gt      <= bus.alu_flag.GT;
                        bus.out_et      <= bus.alu_flag.ET;
                        bus.out_rd      <= rd_q;
                        bus.out_illegal <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb/tb_alu_issue_ctrl.sv - scoreboard bench for alu_issue_ctrl with a behavioural ALU

module tb_alu_issue_ctrl;
    import alu_issue_pkg::*;

`ifdef ALU_MULTICYCLE_DIV_EN
    localparam int DIV_LAT_EXP = 8;
`else
    localparam int DIV_LAT_EXP = 1;
`endif
    localparam int MUL_LAT_EXP = 2;

    typedef struct packed {
        logic [31:0] res;
        logic        gt;
        logic        et;
        logic [3:0]  rd;
        logic        ill;
    } exp_t;

    typedef struct packed {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  rd;
        logic [31:0] res;
        logic        gt;
        logic        et;
        logic        ill;
    } vec_t;

    logic clk;
    logic rst;
    int   n_vec;
    int   n_miss;
    exp_t sb[$];
    exp_t mon_e;
    vec_t vecs[16];
    logic [12:0] cb;

    alu_issue_ctrl_if bus();

    alu_issue_ctrl #(
        .MUL_LATENCY(2),
        .DIV_LATENCY(8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
        $fatal(1, "watchdog");
    end

    // Behavioural ALU answering the one-hot control combinationally.
    assign cb = bus.alu_ctrl;
    always_comb begin
        bus.alu_result = 32'd0;
        case (1'b1)
            cb[0]:  bus.alu_result = bus.alu_a + bus.alu_b;
            cb[1]:  bus.alu_result = bus.alu_a - bus.alu_b;
            cb[2]:  bus.alu_result = bus.alu_a - bus.alu_b;
            cb[3]:  bus.alu_result = bus.alu_a | bus.alu_b;
            cb[4]:  bus.alu_result = bus.alu_a & bus.alu_b;
            cb[5]:  bus.alu_result = ~bus.alu_a;
            cb[6]:  bus.alu_result = bus.alu_a << bus.alu_b[4:0];
            cb[7]:  bus.alu_result = bus.alu_a >> bus.alu_b[4:0];
            cb[8]:  bus.alu_result = 32'($signed(bus.alu_a) >>> bus.alu_b[4:0]);
            cb[9]:  bus.alu_result = bus.alu_a * bus.alu_b;
            cb[10]: bus.alu_result = (bus.alu_b != 0) ? bus.alu_a / bus.alu_b : 32'd0;
            cb[11]: bus.alu_result = (bus.alu_b != 0) ? bus.alu_a % bus.alu_b : 32'd0;
            cb[12]: bus.alu_result = bus.alu_a;
            default: bus.alu_result = 32'd0;
        endcase
        bus.alu_flag.GT = bus.alu_a > bus.alu_b;
        bus.alu_flag.ET = bus.alu_a == bus.alu_b;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: every accepted result is popped from the scoreboard and compared.
    always @(negedge clk) begin
        if (!rst && bus.out_valid && bus.out_ready) begin
            if (sb.size() == 0) begin
                n_vec++;
                n_miss++;
                $display("FAIL unexpected_result: got rd %0d result %h, expected no result", bus.out_rd, bus.out_result);
            end else begin
                mon_e = sb.pop_front();
                chk("out_result",  bus.out_result, mon_e.res);
                chk("out_gt",      32'(bus.out_gt), 32'(mon_e.gt));
                chk("out_et",      32'(bus.out_et), 32'(mon_e.et));
                chk("out_rd",      32'(bus.out_rd), 32'(mon_e.rd));
                chk("out_illegal", 32'(bus.out_illegal), 32'(mon_e.ill));
            end
        end
    end

    function automatic int lat_of(input logic [3:0] op);
        if (op > 4'd12) return 0;
        if (op == 4'd9) return MUL_LAT_EXP;
        if (op == 4'd10 || op == 4'd11) return DIV_LAT_EXP;
        return 1;
    endfunction

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input logic [3:0] r);
        int waited;
        waited       = 0;
        bus.in_valid = 1'b1;
        bus.opcode   = op;
        bus.op_a     = a;
        bus.op_b     = b;
        bus.rd       = r;
        @(negedge clk);
        while (!bus.in_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (!bus.in_ready) begin
            n_vec++;
            n_miss++;
            $display("FAIL issue_timeout: in_ready 0 after %0d cycles, expected 1", waited);
        end
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
    endtask

    task automatic run_vec(input vec_t v);
        int lat;
        lat = lat_of(v.op);
        sb.push_back('{res: v.res, gt: v.gt, et: v.et, rd: v.rd, ill: v.ill});
        issue(v.op, v.a, v.b, v.rd);
        for (int i = 1; i <= lat; i++) begin
            @(negedge clk);
            chk("exec_out_valid", 32'(bus.out_valid), 32'd0);
            chk("exec_in_ready", 32'(bus.in_ready), 32'd0);
            chk("exec_alu_ctrl", 32'(bus.alu_ctrl), 32'd1 << v.op);
            chk("exec_alu_a", bus.alu_a, v.a);
            chk("exec_alu_b", bus.alu_b, v.b);
        end
        @(negedge clk);
        chk("done_out_valid", 32'(bus.out_valid), 32'd1);
        chk("done_alu_ctrl", 32'(bus.alu_ctrl), 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_vec  = 0;
        n_miss = 0;
        rst    = 1'b1;
        bus.in_valid  = 1'b0;
        bus.opcode    = 4'd0;
        bus.op_a      = 32'd0;
        bus.op_b      = 32'd0;
        bus.rd        = 4'd0;
        bus.out_ready = 1'b1;

        vecs[0]  = '{4'd0,  32'd5,          32'd7,    4'd3,  32'd12,         1'b0, 1'b0, 1'b0};
        vecs[1]  = '{4'd1,  32'd20,         32'd5,    4'd1,  32'd15,         1'b1, 1'b0, 1'b0};
        vecs[2]  = '{4'd2,  32'd9,          32'd9,    4'd2,  32'd0,          1'b0, 1'b1, 1'b0};
        vecs[3]  = '{4'd2,  32'd10,         32'd9,    4'd2,  32'd1,          1'b1, 1'b0, 1'b0};
        vecs[4]  = '{4'd3,  32'h000000F0,   32'h0F,   4'd4,  32'h000000FF,   1'b1, 1'b0, 1'b0};
        vecs[5]  = '{4'd4,  32'h000000FF,   32'h3C,   4'd5,  32'h0000003C,   1'b1, 1'b0, 1'b0};
        vecs[6]  = '{4'd5,  32'h0000FFFF,   32'd0,    4'd6,  32'hFFFF0000,   1'b1, 1'b0, 1'b0};
        vecs[7]  = '{4'd6,  32'd1,          32'd4,    4'd7,  32'd16,         1'b0, 1'b0, 1'b0};
        vecs[8]  = '{4'd7,  32'h00000080,   32'd3,    4'd8,  32'h00000010,   1'b1, 1'b0, 1'b0};
        vecs[9]  = '{4'd8,  32'h80000000,   32'd4,    4'd9,  32'hF8000000,   1'b1, 1'b0, 1'b0};
        vecs[10] = '{4'd9,  32'd6,          32'd7,    4'd10, 32'd42,         1'b0, 1'b0, 1'b0};
        vecs[11] = '{4'd10, 32'd100,        32'd7,    4'd11, 32'd14,         1'b1, 1'b0, 1'b0};
        vecs[12] = '{4'd11, 32'd100,        32'd7,    4'd12, 32'd2,          1'b1, 1'b0, 1'b0};
        vecs[13] = '{4'd12, 32'hDEADBEEF,   32'd5,    4'd13, 32'hDEADBEEF,   1'b1, 1'b0, 1'b0};
        vecs[14] = '{4'd13, 32'd3,          32'd3,    4'd14, 32'd0,          1'b0, 1'b0, 1'b1};
        vecs[15] = '{4'd14, 32'd1,          32'd2,    4'd15, 32'd0,          1'b0, 1'b0, 1'b1};

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_alu_ctrl", 32'(bus.alu_ctrl), 32'd0);
        chk("rst_out_result", bus.out_result, 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("post_rst_in_ready", 32'(bus.in_ready), 32'd1);
        @(posedge clk);
        #1;

        // Directed table: every opcode plus two illegal encodings
        for (int i = 0; i < 16; i++) begin
            run_vec(vecs[i]);
        end

        // Backpressure, then simultaneous drain and issue
        bus.out_ready = 1'b0;
        sb.push_back('{res: 32'd3, gt: 1'b0, et: 1'b0, rd: 4'd12, ill: 1'b0});
        issue(4'd0, 32'd1, 32'd2, 4'd12);
        @(negedge clk);
        chk("bp_exec_ctrl", 32'(bus.alu_ctrl), 32'd1);
        @(negedge clk);
        chk("bp_done_valid", 32'(bus.out_valid), 32'd1);
        @(posedge clk);
        #1;
        sb.push_back('{res: 32'd5, gt: 1'b1, et: 1'b0, rd: 4'd13, ill: 1'b0});
        bus.in_valid = 1'b1;
        bus.opcode   = 4'd1;
        bus.op_a     = 32'd9;
        bus.op_b     = 32'd4;
        bus.rd       = 4'd13;
        repeat (3) begin
            @(negedge clk);
            chk("bp_hold_valid", 32'(bus.out_valid), 32'd1);
            chk("bp_in_ready", 32'(bus.in_ready), 32'd0);
            chk("bp_hold_result", bus.out_result, 32'd3);
            chk("bp_hold_rd", 32'(bus.out_rd), 32'd12);
            @(posedge clk);
            #1;
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        chk("drain_in_ready", 32'(bus.in_ready), 32'd1);
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        @(negedge clk);
        chk("nobubble_alu_ctrl", 32'(bus.alu_ctrl), 32'd2);
        chk("nobubble_out_valid", 32'(bus.out_valid), 32'd0);
        chk("nobubble_alu_a", bus.alu_a, 32'd9);
        @(negedge clk);
        chk("nobubble_done_valid", 32'(bus.out_valid), 32'd1);
        @(posedge clk);
        #1;

        // Reset during a DIV: the op must vanish without a result
        bus.out_ready = 1'b0;
        issue(4'd10, 32'd100, 32'd7, 4'd14);
        @(negedge clk);
        chk("rdiv_t1_in_ready", 32'(bus.in_ready), 32'd0);
        chk("rdiv_t1_out_valid", 32'(bus.out_valid), 32'd0);
        @(posedge clk);
        #1;
`ifdef ALU_MULTICYCLE_DIV_EN
        @(negedge clk);
        chk("rdiv_t2_out_valid", 32'(bus.out_valid), 32'd0);
`endif
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rdiv_in_ready", 32'(bus.in_ready), 32'd1);
        chk("rdiv_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rdiv_alu_ctrl", 32'(bus.alu_ctrl), 32'd0);
        chk("rdiv_alu_a", bus.alu_a, 32'd0);
        chk("rdiv_alu_b", bus.alu_b, 32'd0);
        chk("rdiv_out_result", bus.out_result, 32'd0);
        chk("rdiv_out_rd", 32'(bus.out_rd), 32'd0);
        chk("rdiv_out_illegal", 32'(bus.out_illegal), 32'd0);
        bus.out_ready = 1'b1;
        repeat (12) begin
            @(negedge clk);
            chk("rdiv_no_result", 32'(bus.out_valid), 32'd0);
        end

        chk("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
